// File: rtl/ahb_memory_subordinate_pkg.sv
// ahb_memory_subordinate_pkg: AHB enums, subordinate FSM states and memory defaults
// shared by the subordinate top and its byte-lane memory.
package ahb_memory_subordinate_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } ahbTransferEnum;

    typedef enum logic [2:0] {
        SIZE_BYTE, SIZE_HALFWORD, SIZE_WORD, SIZE_DWORD,
        SIZE_4WORD, SIZE_8WORD, SIZE_16WORD, SIZE_32WORD
    } ahbHsizeEnum;

    typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} ahbRespEnum;

    typedef enum logic {AHB_READ = 1'b0, AHB_WRITE = 1'b1} ahbWriteEnum;

    typedef enum logic [2:0] {IDLE_S, WAIT_S, OKAY_S, ERR1_S, ERR2_S} ahbSubStateEnum;

    localparam int          MEM_BYTES_DEF = 4096;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0;

    function automatic logic [7:0] hsize_bytes(input logic [2:0] size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/ahb_memory_subordinate_byte_memory.sv
// ahb_sub_byte_memory: byte-lane storage array with a per-lane write enable and a
// combinational read port, so a read data phase sees writes committed on the prior edge.
module ahb_sub_byte_memory #(
    parameter int LANES      = 2,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic [LANES-1:0]            we_i,
    input  logic [AW-1:0]               waddr_i,
    input  logic [LANES*LANE_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]               raddr_i,
    output logic [LANES*LANE_WIDTH-1:0] rdata_o
);

    logic [LANES-1:0][LANE_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++)
            if (we_i[i]) mem_q[waddr_i][i] <= wdata_i[i*LANE_WIDTH +: LANE_WIDTH];
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_memory_subordinate.sv
// ahb_memory_subordinate: AHB responder backed by a byte-lane memory, with a fixed number
// of wait states per transfer and the two-cycle ERROR response for illegal accesses.
module ahb_memory_subordinate
    import ahb_memory_subordinate_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    MEMORY_WIDTH = 8,
    parameter int                    MEM_BYTES    = MEM_BYTES_DEF,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(BASE_ADDR_DEF),
    parameter int                    WAIT_STATES  = 0,
    parameter int                    HPROT_WIDTH  = 4
) (
    input  logic                    hclk_i,
    input  logic                    hresetn_i,
    input  logic                    hselx_i,
    input  logic [ADDR_WIDTH-1:0]   haddr_i,
    input  logic [1:0]              htrans_i,
    input  logic                    hwrite_i,
    input  logic [2:0]              hsize_i,
    input  logic [2:0]              hburst_i,
    input  logic [HPROT_WIDTH-1:0]  hprot_i,
    input  logic [DATA_WIDTH-1:0]   hwdata_i,
    input  logic [DATA_WIDTH/8-1:0] hwstrb_i,
    input  logic                    hready_i,
    output logic                    hreadyout_o,
    output logic                    hresp_o,
    output logic [DATA_WIDTH-1:0]   hrdata_o
);

    localparam int NB    = DATA_WIDTH / MEMORY_WIDTH;
    localparam int LW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int DEPTH = MEM_BYTES / NB;
    localparam int IW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] LO      = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] HI      = LO + (ADDR_WIDTH+1)'(MEM_BYTES - 1);
    localparam logic [3:0]          WS_LOAD = 4'(WAIT_STATES - 1);

    ahbSubStateEnum  state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NB-1:0]   act_q, act_d;
    logic            write_q, write_d;
    logic [7:0]      sz_b;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH:0]   last;
    logic [NB-1:0]         we;
    logic [DATA_WIDTH-1:0] rd;
    logic            accept, legal, unused_ok;

    assign sz_b   = hsize_bytes(hsize_i);
    assign off    = haddr_i - BASE_ADDR;
    assign last   = {1'b0, haddr_i} + (ADDR_WIDTH+1)'(sz_b - 8'd1);
    assign legal  = int'(sz_b) <= NB && (haddr_i[6:0] & (sz_b[6:0] - 7'd1)) == 7'd0
                    && {1'b0, haddr_i} >= LO && last <= HI;
    assign accept = hselx_i && hready_i && (htrans_i == TRANS_NONSEQ || htrans_i == TRANS_SEQ)
                    && state_q inside {IDLE_S, OKAY_S, ERR2_S};
    assign unused_ok = ^{hburst_i, hprot_i, off, sz_b};

    always_ff @(posedge hclk_i) begin
        if (!hresetn_i) begin
            state_q <= IDLE_S;
            cnt_q   <= '0;
            idx_q   <= '0;
            act_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        act_d   = act_q;
        write_d = write_q;
        if (state_q == WAIT_S) begin
            state_d = (cnt_q == 4'd0) ? OKAY_S : WAIT_S;
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == ERR1_S) begin
            state_d = ERR2_S;
        end else if (accept) begin
            idx_d   = off[IW+LW-1:LW];
            write_d = hwrite_i == AHB_WRITE;
            for (int i = 0; i < NB; i++)
                act_d[i] = i >= int'(off[LW-1:0]) && i < int'(off[LW-1:0]) + int'(sz_b);
            cnt_d   = (legal && WAIT_STATES > 0) ? WS_LOAD : 4'd0;
            state_d = !legal ? ERR1_S : (WAIT_STATES == 0) ? OKAY_S : WAIT_S;
        end else begin
            state_d = IDLE_S;
        end
    end

    // A reset arriving on the completing edge abandons the write.
    assign we = (state_q == OKAY_S && write_q && hresetn_i) ? act_q & hwstrb_i : '0;

    assign hreadyout_o = !(state_q == WAIT_S || state_q == ERR1_S);
    assign hresp_o     = (state_q == ERR1_S || state_q == ERR2_S) ? RESP_ERROR : RESP_OKAY;

    always_comb begin
        hrdata_o = '0;
        for (int i = 0; i < NB; i++)
            if (state_q == OKAY_S && !write_q && act_q[i])
                hrdata_o[i*MEMORY_WIDTH +: MEMORY_WIDTH] = rd[i*MEMORY_WIDTH +: MEMORY_WIDTH];
    end

    ahb_sub_byte_memory #(
        .LANES(NB), .LANE_WIDTH(MEMORY_WIDTH), .DEPTH(DEPTH), .AW(IW)
    ) u_mem (
        .clk_i(hclk_i), .we_i(we), .waddr_i(idx_q), .wdata_i(hwdata_i),
        .raddr_i(idx_q), .rdata_o(rd)
    );

endmodule

// File: tb/tb_ahb_memory_subordinate.sv
// tb_ahb_memory_subordinate: pipelined random and directed AHB traffic into two subordinates
// (zero-wait at base 0, three-wait at base 0x1000) scored against a byte-level memory model.
module tb_ahb_memory_subordinate;

    localparam int          WS0 = 0, WS1 = 3, MEMB = 4096;
    localparam logic [31:0] B0 = 32'h0, B1 = 32'h1000;
    localparam logic [1:0]  ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

    typedef struct {
        bit sel; logic [1:0] trans; bit write; logic [2:0] size;
        logic [31:0] addr; logic [15:0] wdata; logic [1:0] strb;
    } tx_t;
    typedef struct {int waits; bit err; logic [15:0] rdata;} exp_t;

    logic        hclk = 1'b0, hresetn = 1'b0, sel = 1'b0, k = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = ID, hwstrb = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0, hburst = '0;
    logic [3:0]  hprot = '0;
    logic [15:0] hwdata = '0;
    logic        ro0, ro1, rs0, rs1, ro, rs, hready;
    logic [15:0] rd0, rd1, rd;

    exp_t        exp_q[$];
    logic [7:0]  mdl [longint];
    int          n_cmp = 0, n_bad = 0;

    assign ro = k ? ro1 : ro0;
    assign rs = k ? rs1 : rs0;
    assign rd = k ? rd1 : rd0;
    assign hready = ro;

    always #5 hclk = ~hclk;

    ahb_memory_subordinate #(.WAIT_STATES(WS0), .BASE_ADDR(B0)) dut0 (
        .hclk_i(hclk), .hresetn_i(hresetn), .hselx_i(sel && !k), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
        .hprot_i(hprot), .hwdata_i(hwdata), .hwstrb_i(hwstrb), .hready_i(hready),
        .hreadyout_o(ro0), .hresp_o(rs0), .hrdata_o(rd0)
    );

    ahb_memory_subordinate #(.WAIT_STATES(WS1), .BASE_ADDR(B1)) dut1 (
        .hclk_i(hclk), .hresetn_i(hresetn), .hselx_i(sel && k), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
        .hprot_i(hprot), .hwdata_i(hwdata), .hwstrb_i(hwstrb), .hready_i(hready),
        .hreadyout_o(ro1), .hresp_o(rs1), .hrdata_o(rd1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic finish_up();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Reference: legality from address/size arithmetic, data from a byte map keyed per DUT.
    function automatic exp_t model(input tx_t t);
        exp_t   e    = '{0, 1'b0, 16'h0};
        longint a    = longint'(t.addr);
        longint base = k ? longint'(B1) : longint'(B0);
        longint kb   = k ? 64'h100000 : 64'h0;
        int     n    = 1 << t.size;
        int     lane = int'(a % 2);
        if (!t.sel || t.trans == ID || t.trans == BZ) return e;
        e.err = n > 2 || a % n != 0 || a < base || a + n - 1 > base + MEMB - 1;
        if (e.err) begin
            e.waits = 1;
            return e;
        end
        e.waits = k ? WS1 : WS0;
        for (int i = 0; i < 2; i++)
            if (i >= lane && i < lane + n) begin
                if (t.write && t.strb[i]) mdl[kb + a - lane + i] = t.wdata[i*8 +: 8];
                else if (!t.write) e.rdata[i*8 +: 8] = mdl[kb + a - lane + i];
            end
        return e;
    endfunction

    function automatic tx_t mk(input bit w, input int sz, input logic [31:0] a,
                               input logic [15:0] d, input logic [1:0] s, input logic [1:0] tr);
        tx_t t;
        t.sel = 1'b1; t.trans = tr; t.write = w; t.size = 3'(sz);
        t.addr = a; t.wdata = d; t.strb = s;
        return t;
    endfunction

    // Present an address phase, hold it until accepted, then drive its data phase.
    task automatic issue(input tx_t t);
        int   n = 0;
        logic r;
        sel = t.sel; htrans = t.trans; hwrite = t.write; hsize = t.size; haddr = t.addr;
        do begin
            @(negedge hclk);
            r = hready;
            @(posedge hclk);
            #1;
            n++;
            if (n > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: hready low for %0d cycles, expected completion", n);
                finish_up();
            end
        end while (!r);
        hwdata = t.wdata;
        hwstrb = t.strb;
        htrans = ID;
        exp_q.push_back(model(t));
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge hclk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic init_win(input logic [31:0] b);
        for (int i = 0; i < 128; i += 2) issue(mk(1'b1, 1, b + 32'(i), 16'($urandom), 2'b11, NS));
    endtask

    task automatic random_run(input logic [31:0] b, input int cnt);
        for (int j = 0; j < cnt; j++) begin
            tx_t t;
            int  r = int'($urandom_range(0, 19));
            t.sel   = r != 0;
            t.trans = r < 3 ? ID : r < 5 ? BZ : r < 12 ? NS : SQ;
            t.size  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'($urandom_range(0, 1));
            t.addr  = ($urandom_range(0, 15) == 0) ? b + 32'(MEMB) + 32'($urandom_range(0, 3))
                                                   : b + 32'($urandom_range(0, 127));
            t.write = $urandom_range(0, 1) == 1;
            t.wdata = 16'($urandom);
            t.strb  = 2'($urandom_range(0, 3));
            issue(t);
        end
    endtask

    // Monitor: each completing cycle (hreadyout=1) retires one expected response.
    initial begin
        int   low = 0;
        exp_t e;
        forever begin
            @(negedge hclk);
            if (hresetn && exp_q.size() != 0) begin
                if (!ro) begin
                    low++;
                    check(exp_q[0].err ? "err1_hresp" : "wait_hresp", 32'(rs), 32'(exp_q[0].err));
                end else begin
                    e = exp_q.pop_front();
                    check("wait_cycles", 32'(low), 32'(e.waits));
                    check("hresp", 32'(rs), 32'(e.err));
                    check("hrdata", 32'(rd), 32'(e.rdata));
                    low = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        finish_up();
    end

    initial begin
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        check("rst_hreadyout0", 32'(ro0), 32'd1);
        check("rst_hresp0", 32'(rs0), 32'd0);
        check("rst_hrdata0", 32'(rd0), 32'd0);
        check("rst_hreadyout1", 32'(ro1), 32'd1);
        check("rst_hresp1", 32'(rs1), 32'd0);
        check("rst_hrdata1", 32'(rd1), 32'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;

        k = 1'b0;
        init_win(B0);
        issue(mk(1'b1, 1, 32'h10, 16'hBEEF, 2'b11, NS));
        issue(mk(1'b0, 1, 32'h10, 16'h0, 2'b00, NS));
        issue(mk(1'b1, 1, 32'h11, 16'h1234, 2'b11, NS));
        issue(mk(1'b0, 1, 32'h10, 16'h0, 2'b00, NS));
        issue(mk(1'b0, 2, 32'h20, 16'h0, 2'b00, NS));
        issue(mk(1'b1, 1, 32'hFFE, 16'hCAFE, 2'b11, NS));
        issue(mk(1'b0, 1, 32'hFFE, 16'h0, 2'b00, NS));
        issue(mk(1'b0, 0, 32'hFFF, 16'h0, 2'b00, NS));
        issue(mk(1'b0, 1, 32'h1000, 16'h0, 2'b00, NS));
        issue(mk(1'b0, 1, 32'h12, 16'h0, 2'b00, BZ));
        issue(mk(1'b1, 0, 32'h13, 16'h7700, 2'b11, SQ));
        issue(mk(1'b0, 1, 32'h12, 16'h0, 2'b00, NS));
        random_run(B0, 150);
        drain();

        k = 1'b1;
        init_win(B1);
        issue(mk(1'b1, 0, 32'h1021, 16'hA55A, 2'b10, NS));
        issue(mk(1'b0, 1, 32'h1020, 16'h0, 2'b00, NS));
        issue(mk(1'b0, 1, 32'h0FFE, 16'h0, 2'b00, NS));
        issue(mk(1'b0, 1, 32'h2000, 16'h0, 2'b00, NS));
        hburst = 3'b011;
        issue(mk(1'b1, 1, 32'h1040, 16'h1111, 2'b11, NS));
        issue(mk(1'b1, 1, 32'h1042, 16'h2222, 2'b11, SQ));
        issue(mk(1'b1, 1, 32'h1044, 16'hDEAD, 2'b11, BZ));
        issue(mk(1'b1, 1, 32'h1044, 16'h3333, 2'b11, SQ));
        issue(mk(1'b1, 1, 32'h1046, 16'h4444, 2'b11, SQ));
        hburst = 3'b000;
        for (int i = 0; i < 8; i += 2) issue(mk(1'b0, 1, 32'h1040 + 32'(i), 16'h0, 2'b00, NS));
        random_run(B1, 150);
        drain();

        finish_up();
    end

endmodule
